pin_scan_seq: RTL and testbench
===============================

PIN_SCAN_SEQ -- requirements
Module: pin_scan_seq

Interface
REQ-001 Parameter NUM_PINS, default 8: number of scanned pins, legal range 1..99.
REQ-002 Parameter BLINK_HALF, default 6250000: clk_i cycles per pin toggle (2 Hz blink at 25 MHz), legal range >=1.
REQ-003 Parameter DWELL_BLINKS, default 4: full blink periods spent on each pin, legal range >=1.
REQ-004 clk_i  input  1  sole clock, 25 MHz board clock.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 start_i  input  1  level-sampled request to begin a scan at pin 0.
REQ-007 pause_i  input  1  freezes the dwell timers while high.
REQ-008 pins_o  output  NUM_PINS  blink drive; only the selected bit may be high.
REQ-009 pin_idx_o  output  7  index of the pin being reported or driven.
REQ-010 tx_byte_o  output  8  byte offered to the UART transmitter.
REQ-011 tx_send_o  output  1  byte-valid request to the UART transmitter.
REQ-012 tx_done_i  input  1  transmitter acknowledge, synchronous to clk_i.
REQ-013 busy_o  output  1  high in every state except IDLE.
REQ-014 done_o  output  1  one-cycle pulse when a non-looping scan completes.

Function
REQ-015 The FSM SHALL have four states: IDLE, REPORT, DWELL and NEXT.
REQ-016 IDLE->REPORT SHALL occur on the first clk_i edge at which start_i=1; pin_idx_o SHALL be 0 on entry.
REQ-017 start_i SHALL be ignored in every state other than IDLE.
REQ-018 REPORT SHALL send 5 bytes in order: "P" (0x50), tens digit, units digit, CR (0x0D), LF (0x0A). Both digits are ASCII '0'+n of pin_idx_o in decimal.
REQ-019 Handshake: tx_send_o SHALL rise with tx_byte_o valid and stay high, with tx_byte_o stable, until the edge at which tx_done_i=1 is sampled.
REQ-020 Handshake: on the edge after that acknowledge, tx_send_o SHALL be low for exactly one cycle before the next byte is offered.
REQ-021 tx_done_i SHALL be ignored whenever tx_send_o=0.
REQ-022 After the LF byte is acknowledged, the FSM SHALL enter DWELL on the next cycle.
REQ-023 During REPORT, pins_o SHALL be all zero.
REQ-024 On entry to DWELL, the selected pin bit SHALL go high and then toggle every BLINK_HALF cycles. All other bits SHALL stay 0.
REQ-025 DWELL SHALL last exactly 2*DWELL_BLINKS*BLINK_HALF unpaused cycles and SHALL end with the pin low.
REQ-026 While pause_i=1 in DWELL, both counters SHALL hold and pins_o SHALL hold its value. pause_i SHALL have no effect in other states.
REQ-027 NEXT SHALL last one cycle with pins_o=0. It SHALL increment pin_idx_o and go to REPORT if pin_idx_o<NUM_PINS-1; otherwise it follows REQ-035/REQ-036.
REQ-028 Counter widths SHALL be sized from the parameters with no overflow. pin_idx_o SHALL never exceed NUM_PINS-1.

Reset
REQ-029 On rst_i=1, asynchronously and independent of clk_i: the state SHALL become IDLE and pin_idx_o=0.
REQ-030 On rst_i=1, asynchronously: pins_o=0, tx_send_o=0, tx_byte_o=0x00, busy_o=0 and done_o=0.
REQ-031 On rst_i=1, asynchronously: all counters SHALL clear.
REQ-032 Reset asserted in the middle of REPORT SHALL drop tx_send_o immediately. After release, the scan SHALL restart only on a new start_i.
REQ-033 The first operational edge SHALL be the first rising clk_i edge after rst_i falls.

Configuration
REQ-034 The macro PIN_SCAN_LOOP_EN SHALL select end-of-scan behaviour.
REQ-035 With PIN_SCAN_LOOP_EN defined: NEXT on the last pin SHALL wrap pin_idx_o to 0 and go to REPORT. done_o SHALL never pulse, and the scan runs until reset.
REQ-036 Without PIN_SCAN_LOOP_EN: NEXT on the last pin SHALL pulse done_o for one cycle and go to IDLE, with pin_idx_o cleared to 0.

Verification (bench parameters: NUM_PINS=3, BLINK_HALF=4, DWELL_BLINKS=2; tx_done_i returned 3 cycles after each tx_send_o rise)
REQ-037 Single pulse on start_i -> bytes 0x50,0x30,0x30,0x0D,0x0A in order. tx_send_o SHALL be low for 1 cycle between bytes.
REQ-038 After the LF ack -> pins_o reads 001 for 4 cycles, 000 for 4, 001 for 4, 000 for 4. Then NEXT, then the report "P01".
REQ-039 Loop macro off, full run -> three reports (P00, P01, P02), then a single done_o pulse, then busy_o=0 and pin_idx_o=0.
REQ-040 Loop macro on -> the report after "P02" SHALL be "P00" and done_o SHALL stay 0.
REQ-041 pause_i high for 10 cycles mid-DWELL -> pins_o frozen. DWELL SHALL end exactly 10 cycles later than unpaused.
REQ-042 rst_i asserted while tx_send_o=1 during the second byte -> outputs SHALL be at reset values the same cycle. No byte SHALL be sent until start_i is asserted again.

Source files
------------

// File: rtl/pin_scan_seq_if.sv
// rtl/pin_scan_seq_if.sv - byte handshake between the pin scanner and its UART transmitter
interface pin_scan_seq_if;
  logic [7:0] tx_byte_o;
  logic       tx_send_o;
  logic       tx_done_i;

  modport master (output tx_byte_o, output tx_send_o, input tx_done_i);
  modport slave  (input tx_byte_o, input tx_send_o, output tx_done_i);
endinterface

// File: rtl/pin_scan_seq.sv
// rtl/pin_scan_seq.sv - pin blink scanner with UART report; define PIN_SCAN_LOOP_EN to repeat the scan until reset
module pin_scan_seq #(
  parameter int NUM_PINS     = 8,
  parameter int BLINK_HALF   = 6250000,
  parameter int DWELL_BLINKS = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                pause_i,
  output logic [NUM_PINS-1:0] pins_o,
  output logic [6:0]          pin_idx_o,
  output logic                busy_o,
  output logic                done_o,
  pin_scan_seq_if.master      tx
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REPORT = 2'd1;
  localparam logic [1:0] ST_DWELL  = 2'd2;
  localparam logic [1:0] ST_NEXT   = 2'd3;

  // Counters hold up to their terminal value; the +1 keeps the width >= 1 for tiny parameters
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam int HW = $clog2(2 * DWELL_BLINKS + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [BW-1:0] BLINK_ONE  = BW'(1);
  localparam logic [HW-1:0] HALF_LAST  = HW'(2 * DWELL_BLINKS - 1);
  localparam logic [HW-1:0] HALF_ONE   = HW'(1);
  localparam logic [6:0]    LAST_PIN   = 7'(NUM_PINS - 1);
  localparam logic [2:0]    LAST_BYTE  = 3'd4;

  logic [1:0]    state_q, state_d;
  logic [6:0]    pin_idx_q, pin_idx_d;
  logic [2:0]    byte_cnt_q, byte_cnt_d;
  logic          tx_send_q, tx_send_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic [HW-1:0] half_cnt_q, half_cnt_d;
  logic          pin_lvl_q, pin_lvl_d;
  logic          done_q, done_d;

  logic [6:0]    tens;
  logic [6:0]    units;
  logic [7:0]    report_byte;

  // ASCII byte for the current position of the "Pnn\r\n" report line
  always_comb begin
    tens        = pin_idx_q / 7'd10;
    units       = pin_idx_q % 7'd10;
    report_byte = 8'h0A;
    case (byte_cnt_q)
      3'd0:    report_byte = 8'h50;
      3'd1:    report_byte = 8'h30 + {1'b0, tens};
      3'd2:    report_byte = 8'h30 + {1'b0, units};
      3'd3:    report_byte = 8'h0D;
      default: report_byte = 8'h0A;
    endcase
  end

  // Next-state logic for the scan sequencer, UART handshake and blink timers
  always_comb begin
    state_d     = state_q;
    pin_idx_d   = pin_idx_q;
    byte_cnt_d  = byte_cnt_q;
    tx_send_d   = tx_send_q;
    tx_byte_d   = tx_byte_q;
    blink_cnt_d = blink_cnt_q;
    half_cnt_d  = half_cnt_q;
    pin_lvl_d   = pin_lvl_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d    = ST_REPORT;
          pin_idx_d  = '0;
          byte_cnt_d = '0;
          tx_send_d  = 1'b1;
          tx_byte_d  = 8'h50;
        end
      end

      ST_REPORT: begin
        if (tx_send_q) begin
          // The acknowledge only counts while a byte is on offer
          if (tx.tx_done_i) begin
            tx_send_d = 1'b0;
            if (byte_cnt_q == LAST_BYTE) begin
              state_d     = ST_DWELL;
              byte_cnt_d  = '0;
              pin_lvl_d   = 1'b1;
              blink_cnt_d = '0;
              half_cnt_d  = '0;
            end else begin
              byte_cnt_d = byte_cnt_q + 3'd1;
            end
          end
        end else begin
          // One idle cycle after each acknowledge, then offer the next byte
          tx_send_d = 1'b1;
          tx_byte_d = report_byte;
        end
      end

      ST_DWELL: begin
        if (!pause_i) begin
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            pin_lvl_d   = ~pin_lvl_q;
            if (half_cnt_q == HALF_LAST) begin
              half_cnt_d = '0;
              pin_lvl_d  = 1'b0;
              state_d    = ST_NEXT;
            end else begin
              half_cnt_d = half_cnt_q + HALF_ONE;
            end
          end else begin
            blink_cnt_d = blink_cnt_q + BLINK_ONE;
          end
        end
      end

      default: begin
        byte_cnt_d = '0;
        if (pin_idx_q < LAST_PIN) begin
          pin_idx_d = pin_idx_q + 7'd1;
          state_d   = ST_REPORT;
          tx_send_d = 1'b1;
          tx_byte_d = 8'h50;
        end else begin
          pin_idx_d = '0;
`ifdef PIN_SCAN_LOOP_EN
          state_d   = ST_REPORT;
          tx_send_d = 1'b1;
          tx_byte_d = 8'h50;
`else
          state_d   = ST_IDLE;
          done_d    = 1'b1;
`endif
        end
      end
    endcase
  end

  // State and datapath registers, all cleared asynchronously by rst_i
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      pin_idx_q   <= '0;
      byte_cnt_q  <= '0;
      tx_send_q   <= 1'b0;
      tx_byte_q   <= 8'h00;
      blink_cnt_q <= '0;
      half_cnt_q  <= '0;
      pin_lvl_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pin_idx_q   <= pin_idx_d;
      byte_cnt_q  <= byte_cnt_d;
      tx_send_q   <= tx_send_d;
      tx_byte_q   <= tx_byte_d;
      blink_cnt_q <= blink_cnt_d;
      half_cnt_q  <= half_cnt_d;
      pin_lvl_q   <= pin_lvl_d;
      done_q      <= done_d;
    end
  end

  // Drive only the selected pin; pin_lvl_q is low outside DWELL so pins_o is zero there
  always_comb begin
    pins_o = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      pins_o[i] = pin_lvl_q && (pin_idx_q == 7'(i));
    end
  end

  assign pin_idx_o    = pin_idx_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = done_q;
  assign tx.tx_send_o = tx_send_q;
  assign tx.tx_byte_o = tx_byte_q;

endmodule

// File: tb/tb_pin_scan_seq.sv
// tb/tb_pin_scan_seq.sv - self-checking bench for pin_scan_seq
`timescale 1ns/1ps
module tb_pin_scan_seq;
  localparam int NP = 3;
  localparam int BH = 4;
  localparam int DB = 2;
  localparam int DW = 2 * DB * BH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic [NP-1:0] pins;
  logic [6:0]    idx;
  logic          busy;
  logic          done;

  pin_scan_seq_if tx_if ();

  pin_scan_seq #(.NUM_PINS(NP), .BLINK_HALF(BH), .DWELL_BLINKS(DB)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .pause_i(pause),
    .pins_o(pins), .pin_idx_o(idx), .busy_o(busy), .done_o(done), .tx(tx_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 3;
  bit noise = 1'b0;
  int done_cnt = 0;

  logic [NP-1:0] tr_pins [64];
  logic          tr_send [64];
  logic          tr_busy [64];
  logic          tr_done [64];
  logic [6:0]    tr_idx  [64];

  // UART transmitter stand-in: acknowledge lat cycles after tx_send_o rises
  initial begin
    int cnt;
    cnt = 0;
    tx_if.tx_done_i = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        cnt = 0;
        tx_if.tx_done_i = 1'b0;
      end else if (tx_if.tx_send_o === 1'b1) begin
        cnt++;
        tx_if.tx_done_i = (cnt == lat);
      end else begin
        cnt = 0;
        tx_if.tx_done_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (done === 1'b1) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // Reference: report byte k for pin p
  function automatic logic [7:0] exp_byte(int p, int k);
    case (k)
      0:       return 8'h50;
      1:       return 8'(48 + p / 10);
      2:       return 8'(48 + p % 10);
      3:       return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  // Reference: pins n cycles into DWELL of pin p, with a pause driven on cycles [ps, ps+pl)
  function automatic logic [NP-1:0] model_pins(int p, int n, int ps, int pl);
    int paused;
    int u;
    logic [NP-1:0] one;
    paused = 0;
    for (int t = 0; t < n; t++) if (t >= ps && t < ps + pl) paused++;
    u = n - paused;
    one = NP'(1) << p;
    if (u >= DW) return '0;
    return ((u / BH) % 2 == 0) ? one : '0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Wait for the next acknowledged byte; now=1 samples the current negedge first
  task automatic get_byte(input bit now, output logic [7:0] b, output int rc, output int ac,
                          output bit stable, output bit quiet, output bit tmo);
    bit seen;
    bit fin;
    int budget;
    b = '0; rc = -1; ac = -1; stable = 1'b1; quiet = 1'b1; tmo = 1'b0;
    seen = 1'b0; fin = 1'b0; budget = 0;
    while (!fin) begin
      if (!(now && budget == 0)) @(negedge clk);
      budget++;
      if (pins !== '0) quiet = 1'b0;
      if (tx_if.tx_send_o === 1'b1) begin
        if (!seen) begin
          seen = 1'b1;
          rc = cyc;
          b = tx_if.tx_byte_o;
        end else if (tx_if.tx_byte_o !== b) begin
          stable = 1'b0;
        end
        if (tx_if.tx_done_i === 1'b1) begin
          ac = cyc;
          fin = 1'b1;
        end
      end
      if (!fin && budget >= 60) begin
        tmo = 1'b1;
        fin = 1'b1;
      end
    end
  endtask

  // Record the DWELL trace until a new byte is offered or the scanner goes idle
  task automatic run_dwell(input int ps, input int pl, output int n_stop);
    n_stop = -1;
    for (int n = 0; n < 48 && n_stop < 0; n++) begin
      @(negedge clk);
      tr_pins[n] = pins;
      tr_send[n] = tx_if.tx_send_o;
      tr_busy[n] = busy;
      tr_done[n] = done;
      tr_idx[n]  = idx;
      pause = (n >= ps && n < ps + pl);
      if (tx_if.tx_send_o === 1'b1 || busy !== 1'b1) begin
        n_stop = n;
        pause = 1'b0;
      end
    end
    pause = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (pins !== '0) begin errors++; $display("FAIL reset_pins: got %b expected 000", pins); end
    checks++; if (idx !== 7'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", idx); end
    checks++; if (tx_if.tx_send_o !== 1'b0) begin errors++; $display("FAIL reset_send: got %b expected 0", tx_if.tx_send_o); end
    checks++; if (tx_if.tx_byte_o !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h expected 00", tx_if.tx_byte_o); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || tx_if.tx_send_o !== 1'b0) begin errors++; $display("FAIL idle_no_start: got busy=%b send=%b expected 0 0", busy, tx_if.tx_send_o); end
  endtask

  task automatic test_first_report();
    logic [7:0] b;
    int rc, ac, prev_ac;
    bit st, q, tmo;
    lat = 3;
    noise = 1'b0;
    prev_ac = 0;
    pulse_start();
    for (int k = 0; k < 5; k++) begin
      get_byte(1'b0, b, rc, ac, st, q, tmo);
      checks++; if (tmo) begin errors++; $display("FAIL first_timeout k%0d: got no ack expected ack", k); end
      checks++; if (b !== exp_byte(0, k)) begin errors++; $display("FAIL first_byte k%0d: got %h expected %h", k, b, exp_byte(0, k)); end
      checks++; if (!st || !q) begin errors++; $display("FAIL first_stable k%0d: got stable=%b pins_quiet=%b expected 1 1", k, st, q); end
      checks++; if (ac - rc != lat - 1) begin errors++; $display("FAIL first_hold k%0d: got %0d expected %0d", k, ac - rc + 1, lat); end
      if (k > 0) begin
        checks++; if (rc - prev_ac != 2) begin errors++; $display("FAIL first_gap k%0d: got %0d expected 1", k, rc - prev_ac - 1); end
      end
      prev_ac = ac;
    end
  endtask

  task automatic test_dwell_blink();
    int ns;
    logic [7:0] b;
    int rc, ac;
    bit st, q, tmo;
    run_dwell(99, 0, ns);
    for (int n = 0; n <= DW; n++) begin
      checks++; if (tr_pins[n] !== model_pins(0, n, 99, 0)) begin errors++; $display("FAIL dwell0_pins n%0d: got %b expected %b", n, tr_pins[n], model_pins(0, n, 99, 0)); end
    end
    checks++; if (ns != DW + 1) begin errors++; $display("FAIL dwell0_len: got %0d expected %0d", ns - 1, DW); end
    checks++; if (tr_idx[DW] !== 7'd0 || tr_send[DW] !== 1'b0 || tr_busy[DW] !== 1'b1) begin errors++; $display("FAIL next0: got idx=%0d send=%b busy=%b expected 0 0 1", tr_idx[DW], tr_send[DW], tr_busy[DW]); end
    checks++; if (ns >= 0 && tr_idx[ns] !== 7'd1) begin errors++; $display("FAIL idx_after_next: got %0d expected 1", tr_idx[ns]); end
    for (int k = 0; k < 5; k++) begin
      get_byte(k == 0, b, rc, ac, st, q, tmo);
      checks++; if (tmo || b !== exp_byte(1, k)) begin errors++; $display("FAIL report1 k%0d: got %h expected %h", k, b, exp_byte(1, k)); end
    end
  endtask

  task automatic test_pause();
    int ns, ps;
    logic [7:0] b;
    int rc, ac;
    bit st, q, tmo;
    ps = $urandom_range(0, DW - 1);
    run_dwell(ps, 10, ns);
    for (int n = 0; n <= DW + 10; n++) begin
      checks++; if (tr_pins[n] !== model_pins(1, n, ps, 10)) begin errors++; $display("FAIL pause_pins n%0d ps%0d: got %b expected %b", n, ps, tr_pins[n], model_pins(1, n, ps, 10)); end
    end
    checks++; if (ns != DW + 11) begin errors++; $display("FAIL pause_len: got %0d expected %0d", ns - 1, DW + 10); end
    for (int k = 0; k < 5; k++) begin
      get_byte(k == 0, b, rc, ac, st, q, tmo);
      checks++; if (tmo || b !== exp_byte(2, k)) begin errors++; $display("FAIL report2 k%0d: got %h expected %h", k, b, exp_byte(2, k)); end
    end
  endtask

  task automatic test_end_of_scan();
    int ns, d0;
    logic [7:0] b;
    int rc, ac;
    bit st, q, tmo;
    d0 = done_cnt;
    run_dwell(99, 0, ns);
    for (int n = 0; n <= DW; n++) begin
      checks++; if (tr_pins[n] !== model_pins(2, n, 99, 0)) begin errors++; $display("FAIL dwell2_pins n%0d: got %b expected %b", n, tr_pins[n], model_pins(2, n, 99, 0)); end
    end
    checks++; if (ns != DW + 1) begin errors++; $display("FAIL dwell2_len: got %0d expected %0d", ns - 1, DW); end
`ifdef PIN_SCAN_LOOP_EN
    checks++; if (ns >= 0 && (tr_send[ns] !== 1'b1 || tr_idx[ns] !== 7'd0)) begin errors++; $display("FAIL loop_wrap: got send=%b idx=%0d expected 1 0", tr_send[ns], tr_idx[ns]); end
    for (int k = 0; k < 5; k++) begin
      get_byte(k == 0, b, rc, ac, st, q, tmo);
      checks++; if (tmo || b !== exp_byte(0, k)) begin errors++; $display("FAIL loop_report k%0d: got %h expected %h", k, b, exp_byte(0, k)); end
    end
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL loop_done: got %0d pulses expected 0", done_cnt - d0); end
`else
    checks++; if (ns >= 0 && (tr_done[ns] !== 1'b1 || tr_busy[ns] !== 1'b0 || tr_idx[ns] !== 7'd0)) begin errors++; $display("FAIL scan_end: got done=%b busy=%b idx=%0d expected 1 0 0", tr_done[ns], tr_busy[ns], tr_idx[ns]); end
    repeat (3) @(negedge clk);
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL done_pulses: got %0d expected 1", done_cnt - d0); end
    checks++; if (busy !== 1'b0 || tx_if.tx_send_o !== 1'b0) begin errors++; $display("FAIL idle_after_scan: got busy=%b send=%b expected 0 0", busy, tx_if.tx_send_o); end
`endif
    do_reset();
  endtask

  task automatic test_reset_mid_report();
    logic [7:0] b;
    int rc, ac, sends, w;
    bit st, q, tmo;
    lat = $urandom_range(2, 4);
    noise = 1'b0;
    pulse_start();
    get_byte(1'b0, b, rc, ac, st, q, tmo);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (tx_if.tx_send_o !== 1'b1 && w < 20);
    checks++; if (tx_if.tx_send_o !== 1'b1) begin errors++; $display("FAIL rst_setup: got send=%b expected 1", tx_if.tx_send_o); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (tx_if.tx_send_o !== 1'b0 || tx_if.tx_byte_o !== 8'h00) begin errors++; $display("FAIL async_rst_tx: got send=%b byte=%h expected 0 00", tx_if.tx_send_o, tx_if.tx_byte_o); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || pins !== '0 || idx !== 7'd0) begin errors++; $display("FAIL async_rst_out: got busy=%b done=%b pins=%b idx=%0d expected 0 0 000 0", busy, done, pins, idx); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sends = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx_if.tx_send_o !== 1'b0 || busy !== 1'b0) sends++;
    end
    checks++; if (sends != 0) begin errors++; $display("FAIL rst_no_restart: got %0d active cycles expected 0", sends); end
    pulse_start();
    get_byte(1'b0, b, rc, ac, st, q, tmo);
    checks++; if (tmo || b !== 8'h50) begin errors++; $display("FAIL restart_byte: got %h expected 50", b); end
    do_reset();
  endtask

  task automatic test_random();
    logic [7:0] b;
    int rc, ac, prev_ac, ns, ps, pl, d0;
    bit st, q, tmo;
    for (int it = 0; it < 2; it++) begin
      lat = $urandom_range(1, 6);
      noise = 1'b1;
      d0 = done_cnt;
      pulse_start();
      start = 1'b1;
      ns = 0;
      for (int p = 0; p < NP; p++) begin
        prev_ac = 0;
        for (int k = 0; k < 5; k++) begin
          get_byte(p > 0 && k == 0, b, rc, ac, st, q, tmo);
          checks++; if (tmo || b !== exp_byte(p, k) || !st) begin errors++; $display("FAIL rand_byte it%0d p%0d k%0d: got %h expected %h", it, p, k, b, exp_byte(p, k)); end
          if (k > 0) begin
            checks++; if (rc - prev_ac != 2) begin errors++; $display("FAIL rand_gap it%0d p%0d k%0d: got %0d expected 1", it, p, k, rc - prev_ac - 1); end
          end
          prev_ac = ac;
        end
        if (p == 1) start = 1'b0;
        ps = $urandom_range(0, DW - 1);
        pl = $urandom_range(0, 8);
        run_dwell(ps, pl, ns);
        checks++; if (ns != DW + pl + 1) begin errors++; $display("FAIL rand_dwell it%0d p%0d: got %0d expected %0d", it, p, ns - 1, DW + pl); end
      end
`ifdef PIN_SCAN_LOOP_EN
      checks++; if (done_cnt != d0 || ns < 0 || tr_send[ns] !== 1'b1) begin errors++; $display("FAIL rand_end it%0d: got done=%0d expected 0", it, done_cnt - d0); end
`else
      @(negedge clk);
      checks++; if (done_cnt - d0 != 1 || busy !== 1'b0) begin errors++; $display("FAIL rand_end it%0d: got done=%0d busy=%b expected 1 0", it, done_cnt - d0, busy); end
`endif
      do_reset();
    end
    noise = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_report();
    test_dwell_blink();
    test_pause();
    test_end_of_scan();
    test_reset_mid_report();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
